uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle done pulse and queues it in a first-word-fall-through FIFO.
- The CPU-side register interface (or a command parser) drains the FIFO.
- Reports empty, full, occupancy and a sticky overflow flag so dropped bytes are never silent.

---
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through queue with occupancy, full/empty and sticky overflow.
// Optional threshold interrupt output rx_irq is enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo #(
    parameter int DBIT   = 8,
    parameter int DEPTH  = 16,
`ifdef UART_RX_FIFO_THRESH_EN
    parameter int THRESH = DEPTH / 2,
`endif
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_tick,
    input  logic [DBIT-1:0] din,
    input  logic            rd_en,
    input  logic            ovf_clr,
    output logic [DBIT-1:0] dout,
    output logic            empty,
    output logic            full,
    output logic [AW:0]     count,
    output logic            overflow
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    output logic            rx_irq
`endif
);

    logic [DBIT-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            rd_ok, wr_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // A read on the same edge frees a slot, so a write into a full FIFO is still taken.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_tick && (!full || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Dropped write takes priority over a same-edge clear.
        if (wr_tick && !wr_ok) ovf_d = 1'b1;
        else if (ovf_clr)      ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= din;
    end

    assign dout     = empty ? '0 : mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

`ifdef UART_RX_FIFO_THRESH_EN
    logic rx_irq_q, rx_irq_d;

    always_comb begin
        rx_irq_d = (count_d >= (AW+1)'(THRESH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_irq_q <= 1'b0;
        else          rx_irq_q <= rx_irq_d;
    end

    assign rx_irq = rx_irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written corner sequences and random traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DBIT  = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_tick = 1'b0;
    logic [DBIT-1:0] din = '0;
    logic            rd_en = 1'b0;
    logic            ovf_clr = 1'b0;
    logic [DBIT-1:0] dout;
    logic            empty;
    logic            full;
    logic [AW:0]     count;
    logic            overflow;
`ifdef UART_RX_FIFO_THRESH_EN
    logic            rx_irq;
`endif

    uart_rx_fifo #(.DBIT(DBIT), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_tick  (wr_tick),
        .din      (din),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
`ifdef UART_RX_FIFO_THRESH_EN
        ,
        .rx_irq   (rx_irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: contents as a plain queue plus the sticky flag.
    logic [7:0] mq[$];
    bit         m_ovf;

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         r;
        bit         c;
        int         e_cnt;
        logic [7:0] e_dout;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, " count"}, 32'(count), 32'(n));
        chk({tag, " empty"}, 32'(empty), 32'(n == 0));
        chk({tag, " full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, " dout"}, 32'(dout), (n == 0) ? 32'h0 : 32'(mq[0]));
        chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_THRESH_EN
        chk({tag, " rx_irq"}, 32'(rx_irq), 32'(n >= DEPTH / 2));
`endif
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input string tag);
        bit rd_ok, wr_ok;
        wr_tick = w; din = d; rd_en = r; ovf_clr = c;
        @(posedge clk);
        rd_ok = r && (mq.size() > 0);
        wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(d);
        if (w && !wr_ok) m_ovf = 1'b1;
        else if (c)      m_ovf = 1'b0;
        #1;
        wr_tick = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
        chk_model(tag);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 8'h55, 1'b0};
        tbl[1] = '{1'b1, 8'hA3, 1'b0, 1'b0, 2, 8'h55, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hA3, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 8'h3C, 1'b0};
        tbl[6] = '{1'b1, 8'h9E, 1'b1, 1'b0, 1, 8'h9E, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0};

        m_ovf = 1'b0;
        #12;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("reset count", 32'(count), 32'h0);
        chk("reset empty", 32'(empty), 32'h1);
        chk("reset full", 32'(full), 32'h0);
        chk("reset overflow", 32'(overflow), 32'h0);
        chk("reset dout", 32'(dout), 32'h0);
`ifdef UART_RX_FIFO_THRESH_EN
        chk("reset rx_irq", 32'(rx_irq), 32'h0);
`endif

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c, "tbl");
            chk("tbl count", 32'(count), 32'(tbl[i].e_cnt));
            chk("tbl dout", 32'(dout), 32'(tbl[i].e_dout));
            chk("tbl overflow", 32'(overflow), 32'(tbl[i].e_ovf));
        end

        // Fill, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        chk("fill full", 32'(full), 32'h1);
        chk("fill count", 32'(count), 32'(DEPTH));
        step(1'b1, 8'hFF, 1'b0, 1'b0, "drop");
        chk("drop overflow", 32'(overflow), 32'h1);
        chk("drop count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain order", 32'(dout), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        chk("drain empty", 32'(empty), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        chk("clr overflow", 32'(overflow), 32'h0);

        // Full plus simultaneous write/read keeps count and does not flag overflow.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill2");
        step(1'b1, 8'h77, 1'b1, 1'b0, "full wr+rd");
        chk("full wr+rd count", 32'(count), 32'(DEPTH));
        chk("full wr+rd overflow", 32'(overflow), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("last out 77", 32'(dout), 32'h77);
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        end

        // Set beats clear on the same edge.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "fill3");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "drop2");
        step(1'b1, 8'hEE, 1'b0, 1'b1, "drop+clr");
        chk("drop+clr overflow", 32'(overflow), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr2");
        chk("clr2 overflow", 32'(overflow), 32'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain3");

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, "pre-rst");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        chk("async rst count", 32'(count), 32'h0);
        chk("async rst empty", 32'(empty), 32'h1);
        chk("async rst dout", 32'(dout), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 8'h42, 1'b0, 1'b0, "post-rst");
        chk("post-rst dout", 32'(dout), 32'h42);

        // Walk count across DEPTH/2 for the threshold output.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "thr");
        step(1'b1, 8'hC8, 1'b0, 1'b0, "thr8");
`ifdef UART_RX_FIFO_THRESH_EN
        chk("thr8 rx_irq", 32'(rx_irq), 32'h1);
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0, "thr7");
`ifdef UART_RX_FIFO_THRESH_EN
        chk("thr7 rx_irq", 32'(rx_irq), 32'h0);
`endif

        // Random traffic, biased to visit both full and empty.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 2 ? 70 : 35;
            step(($urandom_range(0, 99) < bias), 8'($urandom), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 5), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
